// File: rtl/move_sched_pkg.sv
// Shared types for the move scheduler: move opcodes, arbitration sources, slot states
// and the simultaneous-key priority encoder (down > up > left > right).
package move_sched_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LEFT  = 3'd0,
    OP_RIGHT = 3'd1,
    OP_ROT   = 3'd2,
    OP_DOWN  = 3'd3,
    OP_GRAV  = 3'd4
  } op_e;

  typedef enum logic {
    SRC_KEY  = 1'b0,
    SRC_GRAV = 1'b1
  } src_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  // Bit positions of the key pulses in the packed key vector
  localparam int KEY_BIT_LEFT  = 0;
  localparam int KEY_BIT_RIGHT = 1;
  localparam int KEY_BIT_UP    = 2;
  localparam int KEY_BIT_DOWN  = 3;

  typedef struct packed {
    logic vld;
    logic multi;
    op_e  op;
  } key_enc_t;

  function automatic key_enc_t key_encode(input logic [3:0] keys);
    key_enc_t e;
    e.vld   = |keys;
    e.multi = ($countones(keys) > 1);
    if (keys[KEY_BIT_DOWN])      e.op = OP_DOWN;
    else if (keys[KEY_BIT_UP])   e.op = OP_ROT;
    else if (keys[KEY_BIT_LEFT]) e.op = OP_LEFT;
    else                         e.op = OP_RIGHT;
    return e;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous key-move queue: DEPTH (power of 2) entries, registered count, flush.
// Read data is combinational from the head; a push into a full queue is taken only with a coincident pop.
module move_fifo
  import move_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = OP_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic [AW:0]  cnt,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/move_sched.sv
// Queues key pulses, generates level-scaled gravity ticks, round-robins both onto one valid/ready move slot.
// Key pulse -> valid in 2 clks; slot holds under !mv_ready and reloads on accept (1 move/clk); MOVE_SCHED_DBG_EN adds drop_cnt.
module move_sched
  import move_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GRAV_DIV   = 25000000,
  parameter int CNT_W      = 25,
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [2:0]      level,
  input  logic            key_left,
  input  logic            key_right,
  input  logic            key_up,
  input  logic            key_down,
  output logic            mv_valid,
  output logic [OP_W-1:0] mv_op,
  input  logic            mv_ready,
  output logic [FCW-1:0]  fifo_cnt,
  output logic            ovf
`ifdef MOVE_SCHED_DBG_EN
  ,output logic [7:0]     drop_cnt
`endif
);

  logic [3:0]      keys;
  key_enc_t        enc;
  logic            key_req;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [OP_W-1:0] fifo_dat;
  logic            key_pend;
  logic            grav_av;
  logic            any_pend;
  logic            accept;
  logic            load;
  logic            drop;
  logic            down_acc;
  src_e            gnt;
  src_e            rr_q;
  slot_e           state_q;
  slot_e           state_d;
  op_e             op_q;
  logic            grav_pend;
  logic [CNT_W-1:0] grav_cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W:0]   cnt_inc;
  logic             term;

  assign keys    = {key_down, key_up, key_right, key_left};
  assign enc     = key_encode(keys);
  assign key_req = enable & enc.vld;

  // A full queue still takes the key when the slot pops it in the same cycle
  assign drop = key_req & (enc.multi | (fifo_full & ~fifo_pop));

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OP_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (!enable),
    .push     (key_req),
    .push_dat (enc.op),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .cnt      (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign key_pend = enable & ~fifo_empty;
  assign grav_av  = enable & grav_pend;
  assign any_pend = key_pend | grav_av;
  assign mv_valid = (state_q == SLOT_FULL);
  assign mv_op    = op_q;
  assign accept   = mv_valid & mv_ready;
  assign down_acc = accept & (op_q == OP_DOWN);

  always_comb begin
    gnt = rr_q;
    if (key_pend && !grav_av)      gnt = SRC_KEY;
    else if (!key_pend && grav_av) gnt = SRC_GRAV;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (any_pend) begin
          state_d = SLOT_FULL;
          load    = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (accept) begin
          load = any_pend;
          if (!any_pend) state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign fifo_pop = load & (gnt == SRC_KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      op_q    <= OP_LEFT;
      rr_q    <= SRC_KEY;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q <= (gnt == SRC_KEY) ? op_e'(fifo_dat) : OP_GRAV;
        rr_q <= (gnt == SRC_KEY) ? SRC_GRAV : SRC_KEY;
      end
    end
  end

  // Terminal test is ">=" so a level change that shortens the period wraps at once
  assign period  = CNT_W'(GRAV_DIV >> level);
  assign cnt_inc = {1'b0, grav_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign term    = (cnt_inc >= {1'b0, period});

  always_ff @(posedge clk) begin
    if (rst || !enable || down_acc) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else begin
      grav_cnt <= term ? '0 : cnt_inc[CNT_W-1:0];
      if (term)                          grav_pend <= 1'b1;
      else if (load && gnt == SRC_GRAV)  grav_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

`ifdef MOVE_SCHED_DBG_EN
  logic [2:0] n_drop;
  logic [8:0] drop_sum;

  always_comb begin
    n_drop = 3'd0;
    if (key_req) begin
      n_drop = 3'($countones(keys)) - 3'd1;
      if (fifo_full && !fifo_pop) n_drop = n_drop + 3'd1;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {6'd0, n_drop};

  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_move_sched.sv
// Directed bench for move_sched with a move scoreboard checked on every accepted handshake.
// Gravity runs at GRAV_DIV=16 so level 0 gives P=16 and level 1 gives P=8.
module tb_move_sched;
  import move_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] level;
  logic       key_left, key_right, key_up, key_down;
  logic       mv_valid;
  logic [2:0] mv_op;
  logic       mv_ready;
  logic [2:0] fifo_cnt;
  logic       ovf;
`ifdef MOVE_SCHED_DBG_EN
  logic [7:0] drop_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [2:0] sb_q[$];

  always #5 clk = ~clk;

  move_sched #(
    .FIFO_DEPTH (4),
    .GRAV_DIV   (16),
    .CNT_W      (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .level     (level),
    .key_left  (key_left),
    .key_right (key_right),
    .key_up    (key_up),
    .key_down  (key_down),
    .mv_valid  (mv_valid),
    .mv_op     (mv_op),
    .mv_ready  (mv_ready),
    .fifo_cnt  (fifo_cnt),
    .ovf       (ovf)
`ifdef MOVE_SCHED_DBG_EN
    ,.drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every handshake that completes on the next edge must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && mv_valid === 1'b1 && mv_ready === 1'b1) begin
      n_chk++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_move: got op %0d, expected no move", mv_op);
      end
      if (sb_q.size() != 0) chk("move_op", {29'd0, mv_op}, {29'd0, sb_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [2:0] lvl, input logic rdy);
    rst = 1'b1;
    {key_left, key_right, key_up, key_down} = 4'b0;
    enable   = 1'b1;
    level    = lvl;
    mv_ready = rdy;
    tick(2);
    chk("rst_valid", mv_valid, 0);
    chk("rst_op", mv_op, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("sb_drained", sb_q.size(), 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    level = 3'd0;
    mv_ready = 1'b0;
    {key_left, key_right, key_up, key_down} = 4'b0;

    // Single LEFT pulse: valid two edges after the pulse is sampled, for one cycle
    do_reset(3'd0, 1'b1);
    tick(9);
    key_left = 1'b1; sb_q.push_back(OP_LEFT);
    tick(1); key_left = 1'b0;
    chk("s1_fifo1", fifo_cnt, 1);
    chk("s1_not_yet", mv_valid, 0);
    tick(1);
    chk("s1_valid", mv_valid, 1);
    chk("s1_op", mv_op, OP_LEFT);
    chk("s1_fifo0", fifo_cnt, 0);
    tick(1);
    chk("s1_drop", mv_valid, 0);
    chk("s1_ovf", ovf, 0);

    // Six RIGHT pulses under backpressure: slot + 4 queued, sixth overflows, then 5 back-to-back
    do_reset(3'd0, 1'b0);
    tick(1);
    key_right = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb_q.push_back(OP_RIGHT);
      tick(1);
      if (i == 4) begin
        chk("s2_fifo_full", fifo_cnt, 4);
        chk("s2_no_ovf", ovf, 0);
      end
    end
    key_right = 1'b0;
    chk("s2_fifo_hold", fifo_cnt, 4);
    chk("s2_ovf", ovf, 1);
    chk("s2_slot", mv_valid, 1);
    chk("s2_slot_op", mv_op, OP_RIGHT);
    mv_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick(1);
      if (j < 5) begin
        chk("s2_b2b_valid", mv_valid, 1);
        chk("s2_b2b_fifo", fifo_cnt, 4 - j);
      end else begin
        chk("s2_done", mv_valid, 0);
      end
    end

    // Gravity at level 1 (P=8) with ready: tick lands in the slot every 8 clks
    do_reset(3'd1, 1'b1);
    repeat (3) sb_q.push_back(OP_GRAV);
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      chk("s3_grav_valid", mv_valid, (k == 9 || k == 17 || k == 25));
      if (k == 9 || k == 17 || k == 25) chk("s3_grav_op", mv_op, OP_GRAV);
    end

    // Gravity held 40 clks: later ticks coalesce into a single pending one
    do_reset(3'd1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k >= 9) begin
        chk("s3b_hold_valid", mv_valid, 1);
        chk("s3b_hold_op", mv_op, OP_GRAV);
      end
    end
    sb_q.push_back(OP_GRAV);
    sb_q.push_back(OP_GRAV);
    mv_ready = 1'b1;
    tick(1);
    chk("s3b_reload", mv_valid, 1);
    chk("s3b_reload_op", mv_op, OP_GRAV);
    for (int k = 42; k <= 48; k++) begin
      tick(1);
      chk("s3b_coalesced", mv_valid, 0);
    end
    mv_ready = 1'b0;
    tick(1);
    chk("s3b_next_tick", mv_valid, 1);

    // Two queued keys plus pending gravity: round-robin interleaves them
    do_reset(3'd1, 1'b0);
    tick(1);
    key_left = 1'b1; tick(1); key_left = 1'b0;
    key_up = 1'b1;   tick(1); key_up = 1'b0;
    key_down = 1'b1; tick(1); key_down = 1'b0;
    chk("s4_fifo2", fifo_cnt, 2);
    chk("s4_slot_op", mv_op, OP_LEFT);
    tick(4);
    sb_q.push_back(OP_LEFT);
    sb_q.push_back(OP_GRAV);
    sb_q.push_back(OP_ROT);
    sb_q.push_back(OP_DOWN);
    mv_ready = 1'b1;
    tick(1); chk("s4_rr_grav", mv_op, OP_GRAV);
    tick(1); chk("s4_rr_key", mv_op, OP_ROT);
    tick(1); chk("s4_last_key", mv_op, OP_DOWN);
    tick(1); chk("s4_empty", mv_valid, 0);
    mv_ready = 1'b0;

    // Simultaneous pulses: down > up > left > right, losers set ovf
    do_reset(3'd0, 1'b1);
    tick(1);
    {key_left, key_right, key_up, key_down} = 4'b1111; sb_q.push_back(OP_DOWN);
    tick(1);
    chk("s5_one_enq", fifo_cnt, 1);
    chk("s5_ovf", ovf, 1);
    {key_up, key_down} = 2'b00; sb_q.push_back(OP_LEFT);
    tick(1);
    chk("s5_down_first", mv_op, OP_DOWN);
    chk("s5_fifo", fifo_cnt, 1);
    key_left = 1'b0; key_up = 1'b1; sb_q.push_back(OP_ROT);
    tick(1);
    {key_left, key_right, key_up, key_down} = 4'b0;
    chk("s5_left_beats_right", mv_op, OP_LEFT);
    tick(1);
    chk("s5_up_beats_right", mv_op, OP_ROT);
    tick(1);
    chk("s5_empty", mv_valid, 0);

    // DOWN accepted on the terminal-count edge suppresses that tick; next one a full period later
    do_reset(3'd1, 1'b1);
    tick(5);
    key_down = 1'b1; sb_q.push_back(OP_DOWN);
    tick(1); key_down = 1'b0;
    tick(1);
    chk("s6_down_slot", mv_valid, 1);
    chk("s6_down_op", mv_op, OP_DOWN);
    sb_q.push_back(OP_GRAV);
    for (int k = 8; k <= 16; k++) begin
      tick(1);
      chk("s6_no_grav", mv_valid, 0);
    end
    tick(1);
    chk("s6_grav_valid", mv_valid, 1);
    chk("s6_grav_op", mv_op, OP_GRAV);
    tick(1);
    chk("s6_grav_taken", mv_valid, 0);

    // enable dropped with 3 queued and slot full: flush next clk, slot held until accepted
    do_reset(3'd0, 1'b0);
    tick(1);
    key_left = 1'b1;  tick(1); key_left = 1'b0;
    key_right = 1'b1; tick(1); key_right = 1'b0;
    key_up = 1'b1;    tick(1); key_up = 1'b0;
    key_down = 1'b1;  tick(1); key_down = 1'b0;
    chk("s7_fifo3", fifo_cnt, 3);
    chk("s7_slot_op", mv_op, OP_LEFT);
    enable = 1'b0;
    sb_q.push_back(OP_LEFT);
    tick(1);
    chk("s7_flushed", fifo_cnt, 0);
    chk("s7_slot_kept", mv_valid, 1);
    key_left = 1'b1;
    tick(1); key_left = 1'b0;
    chk("s7_key_ignored", fifo_cnt, 0);
    chk("s7_ovf_clear", ovf, 0);
    tick(2);
    chk("s7_slot_stable", mv_valid, 1);
    chk("s7_op_stable", mv_op, OP_LEFT);
    mv_ready = 1'b1;
    tick(1);
    chk("s7_accepted", mv_valid, 0);
    tick(3);
    chk("s7_idle", mv_valid, 0);
    chk("s7_idle_fifo", fifo_cnt, 0);

    // rst mid-handshake clears slot and queue regardless of mv_ready
    do_reset(3'd0, 1'b0);
    tick(1);
    key_up = 1'b1;   tick(1); key_up = 1'b0;
    key_left = 1'b1; tick(1); key_left = 1'b0;
    chk("s8_slot", mv_valid, 1);
    chk("s8_fifo", fifo_cnt, 1);
    rst = 1'b1;
    mv_ready = 1'b1;
    tick(1);
    chk("s8_rst_valid", mv_valid, 0);
    chk("s8_rst_fifo", fifo_cnt, 0);
    rst = 1'b0;
    mv_ready = 1'b0;
    tick(1);
    chk("sb_final", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
